// File: rtl/apb_bcd_alu_if.sv
// APB bus bundle for apb_bcd_alu.
// Signals: aps_psel, aps_penable, aps_pwrite, aps_paddr, aps_pwdata (master -> slave);
//          aps_prdata, aps_pready, aps_pslverr (slave -> master).
interface apb_bcd_alu_if #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
);
  logic                 aps_psel;
  logic                 aps_penable;
  logic                 aps_pwrite;
  logic [addrWidth-1:0] aps_paddr;
  logic [dataWidth-1:0] aps_pwdata;
  logic [dataWidth-1:0] aps_prdata;
  logic                 aps_pready;
  logic                 aps_pslverr;

  modport slave (
    input  aps_psel, aps_penable, aps_pwrite, aps_paddr, aps_pwdata,
    output aps_prdata, aps_pready, aps_pslverr
  );

  modport master (
    output aps_psel, aps_penable, aps_pwrite, aps_paddr, aps_pwdata,
    input  aps_prdata, aps_pready, aps_pslverr
  );
endinterface

// File: rtl/apb_bcd_alu.sv
// apb_bcd_alu: APB slave doing serial packed-BCD add/sub, DIGITS_PER_CYCLE digits per clock.
// Registers (byte offsets from summatorBaseAddr): ARG1 +0, ARG2 +4, RES +8 (read only),
// STATUS +12 (bit0 carry/borrow, bit1 busy, bit2 invalid digit, bit3 mode).
// Ports: clk, reset_n (async, active low), bus (apb_bcd_alu_if.slave).
// Optional: define BCD_VALIDATE_EN to reject starts whose operands hold nibbles > 9.

// One BCD digit: s = a + (sub ? 9-b : b) + c, decimal-adjusted.
module bcd_digit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_sub,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_bp;
  logic [4:0] w_sum;
  assign w_bp  = i_sub ? (4'd9 - i_b) : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_bp} + {4'd0, i_c};
  assign o_c   = (w_sum > 5'd9);
  // Subtracting 10 modulo 16 on the low nibble equals the low nibble of (sum - 10).
  assign o_s   = o_c ? (w_sum[3:0] - 4'd10) : w_sum[3:0];
endmodule

module apb_bcd_alu #(
  parameter longint unsigned summatorBaseAddr = 0,
  parameter int addrWidth        = 32,
  parameter int dataWidth        = 32,
  parameter int DIGITS_PER_CYCLE = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  apb_bcd_alu_if.slave  bus
);
  localparam int NDIG  = dataWidth / 4;
  localparam int W     = DIGITS_PER_CYCLE * 4;
  localparam int STEPS = NDIG / DIGITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [addrWidth-1:0] BASE = addrWidth'(summatorBaseAddr);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t               r_state, w_state_nxt;
  logic [dataWidth-1:0] r_arg1, r_arg2, r_res, r_acc;
  logic                 r_flag, r_inv, r_mode, r_carry;
  logic [CW-1:0]        r_cnt;

  logic                 w_busy, w_last, w_acc, w_hit, w_unal, w_err, w_wr, w_start, w_bad;
  logic [addrWidth-1:0] w_off;
  logic [1:0]           w_reg;
  logic [dataWidth-1:0] w_status, w_rmux, w_acc_nxt;
  logic [W-1:0]         w_a, w_b, w_s;
  logic [DIGITS_PER_CYCLE:0] w_c;

  assign w_busy = (r_state == S_CALC);
  assign w_last = (r_cnt == CW'(STEPS - 1));

  // ---------------- APB decode ----------------
  assign w_off  = bus.aps_paddr - BASE;
  assign w_hit  = (bus.aps_paddr >= BASE) && (w_off < addrWidth'(16));
  assign w_reg  = w_off[3:2];
  assign w_unal = (bus.aps_paddr[1:0] != 2'b00);
  assign w_acc  = bus.aps_psel && bus.aps_penable && w_hit && reset_n;

  always_comb begin
    w_err = 1'b0;
    if (w_unal)                                 w_err = 1'b1;
    else if (bus.aps_pwrite && w_reg == 2'd2)   w_err = 1'b1;  // RES is read only
    else if (w_busy && (bus.aps_pwrite || w_reg == 2'd2)) w_err = 1'b1;
  end

  assign w_wr    = w_acc && bus.aps_pwrite && !w_err;
  assign w_start = w_wr && (w_reg == 2'd3) && bus.aps_pwdata[0];

  assign w_status = {{(dataWidth-4){1'b0}}, r_mode, r_inv, w_busy, r_flag};

  always_comb begin
    case (w_reg)
      2'd0:    w_rmux = r_arg1;
      2'd1:    w_rmux = r_arg2;
      2'd2:    w_rmux = r_res;
      default: w_rmux = w_status;
    endcase
  end

  assign bus.aps_pready  = w_acc;
  assign bus.aps_pslverr = w_acc && w_err;
  assign bus.aps_prdata  = (w_acc && !bus.aps_pwrite && !w_err) ? w_rmux : '0;

`ifdef BCD_VALIDATE_EN
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (r_arg1[i*4 +: 4] > 4'd9 || r_arg2[i*4 +: 4] > 4'd9) w_bad = 1'b1;
  end
`else
  assign w_bad = 1'b0;
`endif

  // ---------------- digit lanes ----------------
  always_comb begin
    w_a       = r_arg1[int'(r_cnt)*W +: W];
    w_b       = r_arg2[int'(r_cnt)*W +: W];
    w_acc_nxt = r_acc;
    w_acc_nxt[int'(r_cnt)*W +: W] = w_s;
  end

  assign w_c[0] = r_carry;
  for (genvar g = 0; g < DIGITS_PER_CYCLE; g++) begin : g_lane
    bcd_digit u_dig (
      .i_a  (w_a[g*4 +: 4]),
      .i_b  (w_b[g*4 +: 4]),
      .i_sub(r_mode),
      .i_c  (w_c[g]),
      .o_s  (w_s[g*4 +: 4]),
      .o_c  (w_c[g+1])
    );
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && !w_bad) w_state_nxt = S_CALC;
      S_CALC:  if (w_last)            w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arg1  <= '0;
      r_arg2  <= '0;
      r_res   <= '0;
      r_acc   <= '0;
      r_flag  <= 1'b0;
      r_inv   <= 1'b0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_wr && w_reg == 2'd0) r_arg1 <= bus.aps_pwdata;
      if (w_wr && w_reg == 2'd1) r_arg2 <= bus.aps_pwdata;
      if (w_start) begin
        r_mode  <= bus.aps_pwdata[1];
        r_carry <= bus.aps_pwdata[1];  // ten's complement: +1 on subtract
        r_flag  <= 1'b0;
        r_inv   <= w_bad;
        r_cnt   <= '0;
        r_acc   <= '0;
      end
      if (w_busy) begin
        r_acc   <= w_acc_nxt;
        r_carry <= w_c[DIGITS_PER_CYCLE];
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_res  <= w_acc_nxt;
          r_flag <= r_mode ? ~w_c[DIGITS_PER_CYCLE] : w_c[DIGITS_PER_CYCLE];
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_bcd_alu.sv
module tb_apb_bcd_alu;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  apb_bcd_alu_if #(.addrWidth(32), .dataWidth(32)) bus ();

  apb_bcd_alu #(.summatorBaseAddr(0), .addrWidth(32), .dataWidth(32), .DIGITS_PER_CYCLE(2))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [31:0] a1, a2;
    logic        sub;
    logic [31:0] res, st;
  } vec_t;

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // One APB transfer; expectation queued at drive, popped at the access-phase sample.
  // Entered and left at posedge+1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic erdy, input logic [31:0] erd, input logic eerr,
                      input string nm, input logic sel);
    exp_t e, g;
    e.rdy = erdy; e.rdata = erd; e.err = eerr;
    sb.push_back(e);
    bus.aps_psel = sel; bus.aps_penable = 1'b0; bus.aps_pwrite = wr;
    bus.aps_paddr = addr; bus.aps_pwdata = wdata;
    @(posedge clk); #1;
    bus.aps_penable = 1'b1;
    #3;
    g = sb.pop_front();
    total++;
    if (bus.aps_pready !== g.rdy || bus.aps_pslverr !== g.err || bus.aps_prdata !== g.rdata) begin
      bad++;
      $display("FAIL %s: got rdy=%b err=%b rdata=%h, want rdy=%b err=%b rdata=%h", nm,
               bus.aps_pready, bus.aps_pslverr, bus.aps_prdata, g.rdy, g.err, g.rdata);
    end
    @(posedge clk); #1;
    bus.aps_psel = 1'b0; bus.aps_penable = 1'b0; bus.aps_pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic eerr, input string nm);
    xfer(1'b1, addr, d, 1'b1, 32'h0, eerr, nm, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] ed, input logic eerr, input string nm);
    xfer(1'b0, addr, 32'h0, 1'b1, ed, eerr, nm, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h00000025, 32'h00000030, 1'b0, 32'h00000055, 32'h0};
    vecs[1] = '{32'h60308002, 32'h51406555, 1'b0, 32'h11714557, 32'h1};
    vecs[2] = '{32'h00000010, 32'h00000025, 1'b1, 32'h99999985, 32'h9};
    vecs[3] = '{32'h00000100, 32'h00000001, 1'b1, 32'h00000099, 32'h8};
    vecs[4] = '{32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 32'h1};
    vecs[5] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 32'h8};
    vecs[6] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 32'h0};
    vecs[7] = '{32'h00000000, 32'h00000001, 1'b1, 32'h99999999, 32'h9};
    vecs[8] = '{32'h00000019, 32'h00000001, 1'b0, 32'h00000020, 32'h0};
    vecs[9] = '{32'h00000199, 32'h00000001, 1'b0, 32'h00000200, 32'h0};

    bus.aps_psel = 1'b0; bus.aps_penable = 1'b0; bus.aps_pwrite = 1'b0;
    bus.aps_paddr = '0; bus.aps_pwdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);

    // reset state
    rd(32'h0, 32'h0, 1'b0, "rst_arg1");
    rd(32'h4, 32'h0, 1'b0, "rst_arg2");
    rd(32'h8, 32'h0, 1'b0, "rst_res");
    rd(32'hC, 32'h0, 1'b0, "rst_status");

    // misses and unselected transfers
    xfer(1'b1, 32'hff000000, 32'h1234, 1'b0, 32'h0, 1'b0, "miss_wr", 1'b1);
    xfer(1'b0, 32'hff000000, 32'h0,    1'b0, 32'h0, 1'b0, "miss_rd", 1'b1);
    xfer(1'b1, 32'h0,        32'h4321, 1'b0, 32'h0, 1'b0, "nosel_wr", 1'b0);
    rd(32'h0, 32'h0, 1'b0, "arg1_after_miss");

    // error responses
    wr(32'h8, 32'h5, 1'b1, "wr_res_err");
    rd(32'h2, 32'h0, 1'b1, "unal_rd_err");
    wr(32'h1, 32'h55, 1'b1, "unal_wr_err");
    rd(32'h0, 32'h0, 1'b0, "arg1_after_unal");
    rd(32'h8, 32'h0, 1'b0, "res_after_wr");

    // vector table
    for (int i = 0; i < 10; i++) begin
      wr(32'h0, vecs[i].a1, 1'b0, "v_arg1");
      wr(32'h4, vecs[i].a2, 1'b0, "v_arg2");
      wr(32'hC, vecs[i].sub ? 32'h3 : 32'h1, 1'b0, "v_start");
      rd(32'hC, {28'h0, vecs[i].sub, 3'b010}, 1'b0, "v_busy");
      idle(3);
      rd(32'h8, vecs[i].res, 1'b0, $sformatf("v%0d_res", i));
      rd(32'hC, vecs[i].st,  1'b0, $sformatf("v%0d_status", i));
    end

    // STATUS write with bit0=0 has no effect
    wr(32'hC, 32'h2, 1'b0, "nostart_wr");
    rd(32'hC, 32'h0, 1'b0, "nostart_status");

    // busy protection: back-to-back RES read and ARG1 write while computing
    wr(32'h0, 32'h1, 1'b0, "b_arg1");
    wr(32'h4, 32'h2, 1'b0, "b_arg2");
    wr(32'hC, 32'h1, 1'b0, "b_start");
    rd(32'h8, 32'h0, 1'b1, "busy_res_rd");
    wr(32'h0, 32'h7, 1'b1, "busy_arg1_wr");
    idle(2);
    rd(32'h0, 32'h1, 1'b0, "busy_arg1_kept");
    rd(32'h8, 32'h3, 1'b0, "busy_res_done");

    // reset in the middle of CALC
    wr(32'h0, 32'h11, 1'b0, "r_arg1");
    wr(32'h4, 32'h22, 1'b0, "r_arg2");
    wr(32'hC, 32'h1, 1'b0, "r_start");
    #2 reset_n = 1'b0;
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h8, 32'h0, 1'b0, "rstcalc_res");
    rd(32'hC, 32'h0, 1'b0, "rstcalc_status");
    idle(5);
    rd(32'h8, 32'h0, 1'b0, "rstcalc_res_later");

    // invalid digit in ARG1
    wr(32'h0, 32'hA, 1'b0, "inv_arg1");
    wr(32'h4, 32'h0, 1'b0, "inv_arg2");
    wr(32'hC, 32'h1, 1'b0, "inv_start");
`ifdef BCD_VALIDATE_EN
    rd(32'hC, 32'h4, 1'b0, "inv_status_now");
    idle(5);
    rd(32'h8, 32'h0, 1'b0, "inv_res_kept");
    rd(32'hC, 32'h4, 1'b0, "inv_status");
`else
    rd(32'hC, 32'h2, 1'b0, "inv_busy");
    idle(5);
    rd(32'h8, 32'h10, 1'b0, "inv_res");
    rd(32'hC, 32'h0, 1'b0, "inv_status");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_bcd_alu.md
Name: apb_bcd_alu

Overview:
- Parametrised successor to the APB BCD summator: packed-BCD add and subtract with configurable operand width and digit throughput.
- APB slave with a 4-word register window at summatorBaseAddr: ARG1 +0, ARG2 +4, RES +8, STATUS +12.
- Computes serially, DIGITS_PER_CYCLE digits per clock. Adds a subtract mode (ten's complement), a busy flag, and write protection while busy.

Parameters:
- summatorBaseAddr, 0, byte base address of the register window.
- addrWidth, 32, APB address width.
- dataWidth, 32, operand/result width; multiple of 4; NDIG = dataWidth/4 digits.
- DIGITS_PER_CYCLE, 2, digits processed per clock; NDIG must be a multiple of it.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- aps_psel  in  1  APB select.
- aps_penable  in  1  APB enable (access phase).
- aps_pwrite  in  1  1 = write, 0 = read.
- aps_paddr  in  addrWidth  byte address.
- aps_pwdata  in  dataWidth  write data.
- aps_prdata  out  dataWidth  read data.
- aps_pready  out  1  transfer complete.
- aps_pslverr  out  1  transfer error.

Behaviour:
- Reset (async, reset_n=0): ARG1, ARG2, RES, flags and digit counter clear; FSM to IDLE; prdata=0, pready=0, pslverr=0. Reset mid-computation aborts it; nothing is retained.
- Hit: aps_paddr within [base, base+15].
- Access phase (psel & penable & hit): pready=1 combinationally. prdata and pslverr are valid in the same cycle. Write side effects take place on the next clk edge. Zero wait states.
- Miss, or psel=0: pready=0, prdata=0, no register change.
- Unaligned hit (paddr[1:0]!=0): pslverr=1, no side effect.
- STATUS read: bit0 = overflow (add carry-out) or borrow (sub); bit1 = busy; bit2 = invalid-digit error (optional feature); bit3 = mode of last operation; other bits 0.
- STATUS write with bit0=1 in IDLE: latch mode = pwdata[1] (0 add, 1 sub); clear bits 0 and 2; go to CALC. Write with bit0=0: accepted, no effect.
- FSM IDLE -> CALC -> IDLE:
  - CALC lasts NDIG/DIGITS_PER_CYCLE cycles (4 with defaults), lowest digits first.
  - Each digit: sum = a + b' + c, where b' = b (add) or 9-b (sub). If sum > 9: subtract 10, carry = 1.
  - Carry-in is 0 for add, 1 for sub.
  - In the last CALC cycle: RES written; bit0 = final carry (add) or ~final carry (sub); busy cleared.
- Busy (CALC) rules:
  - Read of RES -> pslverr=1, prdata=0.
  - Write to ARG1, ARG2 or STATUS -> pslverr=1, ignored.
  - Reads of ARG1, ARG2, STATUS are allowed.
- Write to RES at any time -> pslverr=1, ignored.
- Sub with ARG2>ARG1 gives the ten's-complement result with borrow=1.
- Results wrap modulo 10^NDIG.
- A start write in the same edge as CALC completes cannot occur: busy is still 1 at that edge, so the write gets pslverr.

Optional Feature:
- Macro BCD_VALIDATE_EN.
- Defined: on start, any ARG1/ARG2 nibble >9 sets STATUS bit2; the operation is not performed; RES unchanged; FSM stays IDLE; bit0 cleared.
- Undefined: no check; bit2 reads 0; invalid nibbles go through the digit adder unchanged (the result is undefined but deterministic).

Test Plan:
- Read/write at 0xff000000 and transfers with psel=0 -> pready=0, registers unchanged, ARG1 reads 0.
- ARG1=0x25, ARG2=0x30, STATUS=0x1, wait 5 clk -> RES=0x55, STATUS=0x0.
- ARG1=0x60308002, ARG2=0x51406555, add -> RES=0x11714557, STATUS bit0=1.
- ARG1=0x10, ARG2=0x25, STATUS=0x3 (sub) -> RES=0x99999985, STATUS=0x9 (borrow, mode sub). ARG1=0x100, ARG2=0x1, sub -> RES=0x99, bit0=0.
- Start, then immediately read RES and write ARG1=0x7 -> both pslverr=1; ARG1 unchanged. Assert reset_n=0 during CALC -> RES=0, busy=0.
- With BCD_VALIDATE_EN: ARG1=0xA, start -> STATUS bit2=1, busy never set, RES unchanged.
